inst_rom_loader: RTL
====================

// Module: inst_rom_loader
// PURPOSE
//  Responder end of the CPU instruction-fetch port: word-organised instruction memory returning
//  the instruction for the PC the pipeline presents. Includes a byte-serial loader (valid/ready)
//  that fills the memory before execution, and holds the fetch port at NOP while loading.
//  Sits beside the pipeline top; fetch data is combinational so IF_ID registers PC and inst together.
// PARAMETERS
//  DEPTH_LOG2  10  log2 of memory depth in 32-bit words (default 1024 words)
//  BASE_ADDR   0   byte address of word 0 on the fetch port
// PORTS
//  clk          in   1             system clock
//  rst          in   1             asynchronous reset, active-low
//  rom_ce_i     in   1             fetch enable from PC stage
//  rom_addr_i   in   32            fetch byte address (PC)
//  rom_data_o   out  32            fetched instruction word
//  ld_start_i   in   1             start a load session (sampled in IDLE/DONE only)
//  ld_len_i     in   DEPTH_LOG2+1  words to load, sampled with ld_start_i
//  ld_valid_i   in   1             loader byte valid
//  ld_byte_i    in   8             loader byte
//  ld_ready_o   out  1             loader can accept a byte
//  ld_busy_o    out  1             load session in progress (CPU should be held)
//  ld_done_o    out  1             level: last session completed, memory valid
//  ld_err_o     out  1             level: last ld_start_i rejected (length > depth)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; byte/word counters=0; ld_ready_o=0, ld_busy_o=0,
//   ld_done_o=0, ld_err_o=0. Memory array is NOT cleared; partially loaded words stay written.
//  FSM: IDLE -> LOAD on ld_start_i with 0 < ld_len_i <= 2**DEPTH_LOG2; latch length, clear counters,
//   clear done/err. ld_len_i==0 -> DONE directly next cycle, no writes. ld_len_i > depth -> stay,
//   ld_err_o=1 next cycle. LOAD -> DONE after last byte of word ld_len-1 accepted. DONE behaves
//   as IDLE for ld_start_i (reload allowed). ld_start_i in LOAD is ignored.
//  Handshake: byte accepted on rising edge with ld_valid_i && ld_ready_o. ld_ready_o=1 exactly
//   in LOAD (registered, no combinational path from ld_valid_i). Producer may hold valid low any time.
//  Packing: big-endian; byte0 -> [31:24], byte3 -> [7:0]. Word written to mem[word_cnt] on the
//   edge accepting byte3; word_cnt increments same edge; byte_cnt wraps 3->0.
//  Fetch (combinational): rom_data_o = 32'h0 (NOP) if rom_ce_i=0, or state==LOAD, or
//   address outside [BASE_ADDR, BASE_ADDR+4*depth); else mem[(rom_addr_i-BASE_ADDR)>>2].
//   rom_addr_i[1:0] ignored (no misalign trap).
//  ld_busy_o=1 in LOAD. ld_done_o set entering DONE, held until next accepted ld_start_i or reset.
//  Reset mid-LOAD: session aborted, pending bytes of incomplete word discarded, done stays 0.
//  Width rules: word_cnt DEPTH_LOG2+1 bits to compare to full depth; no wrap past depth.
// STRUCTURE
//  Shared defines header: InstBus, InstAddrBus, ZeroWord (NOP), loader state encodings
//   (LD_IDLE, LD_LOAD, LD_DONE), byte-lane constants.
//  One sub-module: ld_word_packer (byte_cnt + 24-bit shift holding reg; outputs word + word_valid).
//  Top holds FSM, word counter, memory array and fetch mux.
// TESTING
//  1. Reset, start len=2, bytes 34 08 00 05 3C 09 00 0A -> mem[0]=34080005, mem[1]=3C09000A,
//     ld_done_o=1 one cycle after 8th byte; fetch addr 0x4 with ce=1 returns 3C09000A.
//  2. During LOAD, ce=1 addr=0 -> rom_data_o=0; ce=0 at any time -> 0; addr=4*depth -> 0.
//  3. Valid gaps: bytes with ld_valid_i toggling every other cycle -> same words as test 1,
//     no duplicate/skip; ld_ready_o constant 1 in LOAD.
//  4. len=depth+1 -> ld_err_o=1, state stays IDLE, no writes; len=0 -> ld_done_o=1, mem unchanged.
//  5. Reset asserted after 6 of 8 bytes -> mem[0] written, mem[1] unchanged, all outputs 0;
//     new session after release loads correctly from word 0.
//  6. ld_start_i pulsed mid-LOAD -> ignored, counters continue; reload from DONE overwrites words.

Source files
------------

// File: rtl/inst_rom_loader_pkg.sv
// Shared types and constants for the instruction ROM and its byte-serial loader.
package inst_rom_loader_pkg;

    localparam int INST_W = 32;

    typedef logic [INST_W-1:0] inst_bus_t;
    typedef logic [31:0]       inst_addr_bus_t;

    localparam inst_bus_t ZERO_WORD = '0;

    typedef enum logic [1:0] {
        LD_IDLE = 2'd0,
        LD_LOAD = 2'd1,
        LD_DONE = 2'd2
    } ld_state_e;

    localparam int         BYTES_PER_WORD = 4;
    localparam logic [1:0] LAST_BYTE_LANE = 2'd3;

endpackage

// File: rtl/inst_rom_loader_packer.sv
// Big-endian byte-to-word packer: the first byte of a word lands in [31:24].
// word_valid pulses in the cycle the fourth byte is accepted.
module ld_word_packer
    import inst_rom_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       byte_en,
    input  logic [7:0] byte_in,
    output inst_bus_t  word,
    output logic       word_valid
);

    logic [1:0]  byte_cnt;
    logic [23:0] hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_cnt <= '0;
            hold     <= '0;
        end else if (clr) begin
            byte_cnt <= '0;
            hold     <= '0;
        end else if (byte_en) begin
            byte_cnt <= byte_cnt + 2'd1;
            hold     <= {hold[15:0], byte_in};
        end
    end

    assign word       = {hold, byte_in};
    assign word_valid = byte_en && (byte_cnt == LAST_BYTE_LANE);

endmodule

// File: rtl/inst_rom_loader.sv
// Instruction memory on the fetch port, filled beforehand by a byte-serial loader.
// Fetch returns NOP while a load is in progress or the PC is out of range.
module inst_rom_loader
    import inst_rom_loader_pkg::*;
#(
    parameter int             DEPTH_LOG2 = 10,
    parameter inst_addr_bus_t BASE_ADDR  = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rom_ce_i,
    input  inst_addr_bus_t        rom_addr_i,
    output inst_bus_t             rom_data_o,
    input  logic                  ld_start_i,
    input  logic [DEPTH_LOG2:0]   ld_len_i,
    input  logic                  ld_valid_i,
    input  logic [7:0]            ld_byte_i,
    output logic                  ld_ready_o,
    output logic                  ld_busy_o,
    output logic                  ld_done_o,
    output logic                  ld_err_o
);

    localparam int                DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2+1)'(DEPTH);

    ld_state_e             state, state_nxt;
    logic [DEPTH_LOG2:0]   len_q, word_cnt;
    logic                  done_q, err_q;
    inst_bus_t             mem [DEPTH];

    logic      start_ok, len_bad, len_zero, accept, word_valid, last_word;
    inst_bus_t word;

    assign start_ok  = ld_start_i && (state != LD_LOAD);
    assign len_bad   = ld_len_i > DEPTH_CNT;
    assign len_zero  = (ld_len_i == '0);
    assign accept    = ld_valid_i && ld_ready_o;
    assign last_word = word_valid && ((word_cnt + 1'b1) == len_q);

    ld_word_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_ok),
        .byte_en    (accept),
        .byte_in    (ld_byte_i),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= LD_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LD_IDLE, LD_DONE:
                if (ld_start_i && !len_bad) state_nxt = len_zero ? LD_DONE : LD_LOAD;
            LD_LOAD:
                if (last_word) state_nxt = LD_DONE;
            default: state_nxt = LD_IDLE;
        endcase
    end

    // A rejected start only raises err; done from a prior session survives it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q    <= '0;
            word_cnt <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (start_ok) begin
            if (len_bad) begin
                err_q <= 1'b1;
            end else begin
                err_q    <= 1'b0;
                done_q   <= len_zero;
                len_q    <= ld_len_i;
                word_cnt <= '0;
            end
        end else if (word_valid) begin
            word_cnt <= word_cnt + 1'b1;
            if (last_word) done_q <= 1'b1;
        end
    end

    // Memory is deliberately not reset so words loaded before an abort survive.
    always_ff @(posedge clk) begin
        if (word_valid) mem[word_cnt[DEPTH_LOG2-1:0]] <= word;
    end

    assign ld_ready_o = (state == LD_LOAD);
    assign ld_busy_o  = (state == LD_LOAD);
    assign ld_done_o  = done_q;
    assign ld_err_o   = err_q;

    // BASE_ADDR is assumed word aligned, so the index is a low-bit subtraction.
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] word_idx;

    assign in_range = (rom_addr_i >= BASE_ADDR) &&
                      ({1'b0, rom_addr_i} < ({1'b0, BASE_ADDR} + (33'(DEPTH) << 2)));
    assign word_idx = rom_addr_i[DEPTH_LOG2+1:2] - BASE_ADDR[DEPTH_LOG2+1:2];

    assign rom_data_o = (rom_ce_i && (state != LD_LOAD) && in_range) ? mem[word_idx] : ZERO_WORD;

endmodule
